// File: rtl/spi_axil_pkg.sv
// Shared constants and types for the SPI AXI-Lite register bank.
package spi_axil_pkg;

   // Register word indices
   localparam int unsigned REG_CTRL     = 0;
   localparam int unsigned REG_STATUS   = 1;
   localparam int unsigned REG_TXDATA   = 2;
   localparam int unsigned REG_SCRATCH0 = 3;

   // CTRL bit positions
   localparam int unsigned CTRL_ENABLE_BIT = 0;
   localparam int unsigned CTRL_FLUSH_BIT  = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT = 2;

   // STATUS bit positions; tx_count occupies [7:0]
   localparam int unsigned STAT_FULL_BIT  = 8;
   localparam int unsigned STAT_EMPTY_BIT = 9;
   localparam int unsigned STAT_BUSY_BIT  = 10;
   localparam int unsigned STAT_IRQ_BIT   = 11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Bit order matches the CTRL register layout (enable at bit 0)
   typedef struct packed {
      logic irq_en;
      logic flush;
      logic enable;
   } ctrl_t;

   // Byte-lane merge of a write into an existing word
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module spi_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer, count and storage update; flush wins over push and pop
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/spi_axil_regbank.sv
// AXI-Lite register bank feeding an SPI TX FIFO.
// Optional feature: define SPI_AXIL_REGBANK_IRQ_EN for the drain-complete interrupt.
module spi_axil_regbank
   import spi_axil_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 2 + $clog2(NUM_REGS)
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic                    spi_busy,
   output logic                    irq
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned NSCR  = NUM_REGS - REG_SCRATCH0;

   ctrl_t             ctrl_q, ctrl_d;
   logic [31:0]       scratch_q [NSCR];
   logic [31:0]       scratch_d [NSCR];
   logic              bvalid_q, rvalid_q;
   logic [1:0]        bresp_q, rresp_q, bresp_d, rresp_d;
   logic [31:0]       rdata_q, rdata_d, status_word;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              wr_hs, rd_hs, wr_oor, rd_oor, wr_ctrl, wr_tx;
   logic              push, pop, flush, fifo_full, fifo_empty, irq_pend_bit;
   logic [CNT_W-1:0]  fifo_count;
   logic [3:0]        unused_addr_bits;

   assign unused_addr_bits = {S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
   assign wr_idx  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
   assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign wr_oor  = 32'(wr_idx) >= NUM_REGS;
   assign rd_oor  = 32'(rd_idx) >= NUM_REGS;

   // Ready is gated by reset so a held VALID cannot handshake while in reset
   assign wr_hs   = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !S_AXI_ARESET;
   assign rd_hs   = S_AXI_ARVALID && !rvalid_q && !S_AXI_ARESET;
   assign S_AXI_AWREADY = wr_hs;
   assign S_AXI_WREADY  = wr_hs;
   assign S_AXI_ARREADY = rd_hs;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

   assign wr_ctrl = wr_hs && (wr_idx == IDX_W'(REG_CTRL));
   assign wr_tx   = wr_hs && (wr_idx == IDX_W'(REG_TXDATA));
   assign flush   = wr_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_FLUSH_BIT];
   // Fullness is judged before any same-cycle pop, so a write into a full FIFO is dropped
   assign push    = wr_tx && !fifo_full;
   assign tx_valid = ctrl_q.enable && !fifo_empty;
   assign pop     = tx_valid && tx_ready;
   assign bresp_d = (wr_oor || (wr_tx && fifo_full)) ? RESP_SLVERR : RESP_OKAY;

   spi_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk_i   (S_AXI_ACLK),
      .rst_i   (S_AXI_ARESET),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (S_AXI_WDATA),
      .rdata_o (tx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef SPI_AXIL_REGBANK_IRQ_EN
   logic irq_pend_q, irq_pend_d, irq_set, irq_clr;

   assign irq_set = pop && !push && !flush && (fifo_count == CNT_W'(1));
   assign irq_clr = wr_hs && (wr_idx == IDX_W'(REG_STATUS)) && S_AXI_WSTRB[1] &&
                    S_AXI_WDATA[STAT_IRQ_BIT];

   // Pending flag: a drain event in the same cycle beats a W1C clear
   always_comb begin
      irq_pend_d = irq_pend_q;
      if (irq_clr) irq_pend_d = 1'b0;
      if (irq_set) irq_pend_d = 1'b1;
   end

   // Pending flag register
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) irq_pend_q <= 1'b0;
      else              irq_pend_q <= irq_pend_d;
   end

   assign irq          = irq_pend_q && ctrl_q.irq_en;
   assign irq_pend_bit = irq_pend_q;
`else
   assign irq          = 1'b0;
   assign irq_pend_bit = 1'b0;
`endif

   // STATUS word assembly
   always_comb begin
      status_word                 = '0;
      status_word[7:0]            = 8'(fifo_count);
      status_word[STAT_FULL_BIT]  = fifo_full;
      status_word[STAT_EMPTY_BIT] = fifo_empty;
      status_word[STAT_BUSY_BIT]  = spi_busy;
      status_word[STAT_IRQ_BIT]   = irq_pend_bit;
   end

   // Register write decode with byte strobes; flush is a pulse and never stored
   always_comb begin
      ctrl_d    = ctrl_q;
      scratch_d = scratch_q;
      if (wr_ctrl && S_AXI_WSTRB[0]) begin
         ctrl_d.enable = S_AXI_WDATA[CTRL_ENABLE_BIT];
         ctrl_d.irq_en = S_AXI_WDATA[CTRL_IRQ_EN_BIT];
      end
      ctrl_d.flush = 1'b0;
      for (int i = 0; i < NSCR; i++) begin
         if (wr_hs && (wr_idx == IDX_W'(i + REG_SCRATCH0))) begin
            scratch_d[i] = apply_strb(scratch_q[i], S_AXI_WDATA, S_AXI_WSTRB);
         end
      end
   end

   // Read mux over pre-write register values
   always_comb begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      if (rd_oor) begin
         rresp_d = RESP_SLVERR;
      end else if (rd_idx == IDX_W'(REG_CTRL)) begin
         rdata_d = {29'b0, ctrl_q};
      end else if (rd_idx == IDX_W'(REG_STATUS)) begin
         rdata_d = status_word;
      end else begin
         for (int i = 0; i < NSCR; i++) begin
            if (rd_idx == IDX_W'(i + REG_SCRATCH0)) rdata_d = scratch_q[i];
         end
      end
   end

   // Channel state and register storage
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         ctrl_q   <= '0;
         for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         scratch_q <= scratch_d;
         if (wr_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= bresp_d;
         end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
         if (rd_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_axil_regbank.sv
// Self-checking bench for spi_axil_regbank using scoreboard queues for B, R and TX streams.
module tb_spi_axil_regbank;

   localparam int unsigned AW = 6;  // one extra address bit so index NUM_REGS is reachable

`ifdef SPI_AXIL_REGBANK_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata, tx_data;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          tx_valid, tx_ready, spi_busy, irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int first_pop = 0;
   int last_pop = 0;

   logic [1:0]  bresp_q[$];
   logic [33:0] rd_q[$];
   logic [31:0] tx_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_axil_regbank #(
      .NUM_REGS   (8),
      .FIFO_DEPTH (8),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (AW)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .spi_busy      (spi_busy),
      .irq           (irq)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Callers start and return at posedge+1
   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
      logic hs = 1'b0;
      logic got = 1'b0;
      bresp_q.push_back(exp_resp);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         hs = awready && wready;
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check_eq("aw_handshake", {31'b0, hs}, 32'd1);
      for (int i = 0; i < 20 && !got; i++) begin
         if (bvalid) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check_eq("bvalid_seen", {31'b0, got}, 32'd1);
      if (got) begin
         check_eq("bresp", {30'b0, bresp}, {30'b0, bresp_q.pop_front()});
         bready = 1'b1;
         @(posedge clk); #1;
         bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      logic hs = 1'b0;
      logic got = 1'b0;
      logic [33:0] e;
      rd_q.push_back({exp_resp, exp_data});
      araddr = addr; arvalid = 1'b1;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         hs = arready;
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      check_eq("ar_handshake", {31'b0, hs}, 32'd1);
      for (int i = 0; i < 20 && !got; i++) begin
         if (rvalid) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check_eq("rvalid_seen", {31'b0, got}, 32'd1);
      if (got) begin
         e = rd_q.pop_front();
         check_eq("rdata", rdata, e[31:0]);
         check_eq("rresp", {30'b0, rresp}, {30'b0, e[33:32]});
         rready = 1'b1;
         @(posedge clk); #1;
         rready = 1'b0;
      end
   endtask

   // TX stream monitor: every pop must match the oldest accepted TXDATA write
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         check_eq("tx_expected", {31'b0, tx_q.size() != 0}, 32'd1);
         if (tx_q.size() != 0) check_eq("tx_data", tx_data, tx_q.pop_front());
         if (pop_cnt == 0) first_pop = cyc;
         last_pop = cyc;
         pop_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      bready = 1'b0; rready = 1'b0; tx_ready = 1'b0; spi_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_awready", {31'b0, awready}, 32'd0);
      check_eq("rst_arready", {31'b0, arready}, 32'd0);
      check_eq("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check_eq("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check_eq("rst_txvalid", {31'b0, tx_valid}, 32'd0);
      check_eq("rst_txdata", tx_data, 32'd0);
      check_eq("rst_irq", {31'b0, irq}, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Strobed scratch write and plain reads
      axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00);
      axi_write(6'h0C, 32'hA5A5_0001, 4'h3, 2'b00);
      axi_read(6'h0C, 32'hFFFF_0001, 2'b00);
      axi_write(6'h1C, 32'hDEAD_BEEF, 4'hC, 2'b00);
      axi_read(6'h1C, 32'hDEAD_0000, 2'b00);
      axi_read(6'h00, 32'h0, 2'b00);
      axi_read(6'h08, 32'h0, 2'b00);

      // Out-of-range index
      axi_read(6'h20, 32'h0, 2'b10);
      axi_write(6'h20, 32'h1234_5678, 4'hF, 2'b10);
      axi_write(6'h10, 32'h0BAD_CAFE, 4'hF, 2'b00);
      axi_read(6'h10, 32'h0BAD_CAFE, 2'b00);

      // Same-cycle read and write return the old value
      axi_write(6'h14, 32'h1111_1111, 4'hF, 2'b00);
      fork
         axi_write(6'h14, 32'h2222_2222, 4'hF, 2'b00);
         axi_read(6'h14, 32'h1111_1111, 2'b00);
      join
      axi_read(6'h14, 32'h2222_2222, 2'b00);

      // Fill the FIFO with enable clear, overflow, then drain
      for (int i = 0; i < 8; i++) begin
         tx_q.push_back(32'hC0DE_0000 + i);
         axi_write(6'h08, 32'hC0DE_0000 + i, 4'h1, 2'b00);
      end
      axi_write(6'h08, 32'hBAD0_0009, 4'hF, 2'b10);
      axi_read(6'h04, 32'h0000_0108, 2'b00);
      check_eq("disabled_txvalid", {31'b0, tx_valid}, 32'd0);
      tx_ready = 1'b1;
      pop_cnt = 0;
      axi_write(6'h00, 32'h1, 4'hF, 2'b00);
      repeat (12) @(posedge clk);
      #1;
      check_eq("drain_pops", pop_cnt, 32'd8);
      check_eq("drain_back2back", last_pop - first_pop, 32'd7);
      check_eq("drain_left", tx_q.size(), 32'd0);
      axi_read(6'h04, IRQ_ON ? 32'h0000_0A00 : 32'h0000_0200, 2'b00);
      check_eq("irq_masked", {31'b0, irq}, 32'd0);
      axi_write(6'h04, 32'h800, 4'hF, 2'b00);
      axi_read(6'h04, 32'h0000_0200, 2'b00);

      // Disable retains contents; flush empties at once
      axi_write(6'h00, 32'h0, 4'hF, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tx_q.push_back(32'h5500_0000 + i);
         axi_write(6'h08, 32'h5500_0000 + i, 4'hF, 2'b00);
      end
      axi_read(6'h04, 32'h0000_0003, 2'b00);
      check_eq("retain_txvalid", {31'b0, tx_valid}, 32'd0);
      axi_write(6'h00, 32'h3, 4'hF, 2'b00);
      tx_q.delete();
      check_eq("flush_txvalid", {31'b0, tx_valid}, 32'd0);
      axi_read(6'h04, 32'h0000_0200, 2'b00);
      axi_read(6'h00, 32'h0000_0001, 2'b00);

      // Drain-complete interrupt
      axi_write(6'h00, 32'h5, 4'hF, 2'b00);
      tx_q.push_back(32'h1234_5678);
      axi_write(6'h08, 32'h1234_5678, 4'hF, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      check_eq("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
      axi_write(6'h04, 32'h800, 4'hF, 2'b00);
      check_eq("irq_clr", {31'b0, irq}, 32'd0);

      // Reset while a write response is outstanding
      tx_ready = 1'b0;
      axi_write(6'h00, 32'h0, 4'hF, 2'b00);
      axi_write(6'h08, 32'h7777_0001, 4'hF, 2'b00);
      awaddr = 6'h18; wdata = 32'h6666_6666; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check_eq("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_bvalid", {31'b0, bvalid}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      axi_read(6'h00, 32'h0, 2'b00);
      axi_read(6'h04, 32'h0000_0200, 2'b00);
      axi_read(6'h0C, 32'h0, 2'b00);
      axi_read(6'h18, 32'h0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
